// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register-file completer:
// FSM states, bus widths, the ID register default and access-error decode.
package apb_pkg;

  localparam int D_WIDTH = 32;
  localparam int STRB_W  = 4;
  localparam logic [31:0] ID_VALUE = 32'hA9B0_0001;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    WAIT
  } apb_state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_ALIGN,
    ERR_RANGE,
    ERR_RO
  } err_cause_e;

  // Register 0 holds the read-only ID, so any write to word 0 is illegal.
  function automatic err_cause_e decode_err(input logic [D_WIDTH-1:0] addr,
                                            input logic               write,
                                            input int                 num_regs);
    if (addr[1:0] != 2'b00)                               return ERR_ALIGN;
    if (addr[D_WIDTH-1:2] >= (D_WIDTH-2)'(num_regs))      return ERR_RANGE;
    if (write && (addr[D_WIDTH-1:2] == '0))               return ERR_RO;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/apb_regfile_store.sv
// Word register bank with byte-strobe writes, combinational read mux,
// per-register write pulses and a constant read-only register 0.
module apb_regfile_store #(
  parameter int                  D_WIDTH  = apb_pkg::D_WIDTH,
  parameter int                  NUM_REGS = 16,
  parameter logic [D_WIDTH-1:0]  ID_VALUE = apb_pkg::ID_VALUE,
  localparam int                 IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic                          we,
  input  logic [IDX_W-1:0]              idx,
  input  logic [D_WIDTH-1:0]            wdata,
  input  logic [apb_pkg::STRB_W-1:0]    strb,
  output logic [D_WIDTH-1:0]            rd_data,
  output logic [NUM_REGS*D_WIDTH-1:0]   reg_q,
  output logic [NUM_REGS-1:0]           wr_pulse
);
  import apb_pkg::*;

  logic [D_WIDTH-1:0] regs [NUM_REGS];
  logic [D_WIDTH-1:0] strb_mask;

  always_comb begin
    strb_mask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      strb_mask[b*8 +: 8] = {8{strb[b]}};
    end
  end

  for (genvar n = 0; n < NUM_REGS; n++) begin : g_reg
    if (n == 0) begin : g_ro
      assign regs[n] = ID_VALUE;
    end else begin : g_rw
      logic [D_WIDTH-1:0] q;
      // NOTE: each word is its own flop bank with an async reset; a RAM macro
      // could not be cleared on presetn, so this array must stay in flops.
      always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
          q <= '0;
        end else if (we && (idx == IDX_W'(n))) begin
          q <= (q & ~strb_mask) | (wdata & strb_mask);
        end
      end
      assign regs[n] = q;
    end
    assign reg_q[n*D_WIDTH +: D_WIDTH] = regs[n];
  end

  assign rd_data = (int'(idx) < NUM_REGS) ? regs[idx] : '0;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) wr_pulse <= '0;
    else          wr_pulse <= we ? (NUM_REGS'(1) << idx) : '0;
  end

endmodule

// File: rtl/apb_completer_regfile.sv
// APB4 completer: setup capture, programmable wait states, error decode and
// a single-cycle pready, fronting the apb_regfile_store register bank.
module apb_completer_regfile #(
  parameter int                 D_WIDTH  = apb_pkg::D_WIDTH,
  parameter int                 NUM_REGS = 16,
  parameter logic [D_WIDTH-1:0] ID_VALUE = apb_pkg::ID_VALUE
) (
  input  logic                         pclk,
  input  logic                         presetn,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [D_WIDTH-1:0]           paddr,
  input  logic [D_WIDTH-1:0]           pwdata,
  input  logic [3:0]                   pstrb,
  input  logic [2:0]                   pprot,
  input  logic [3:0]                   wait_cfg,
  output logic [D_WIDTH-1:0]           prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic [NUM_REGS*D_WIDTH-1:0]  reg_q,
  output logic [NUM_REGS-1:0]          wr_pulse
);
  import apb_pkg::*;

  localparam int IDX_W = $clog2(NUM_REGS);

  apb_state_e           state;
  logic [3:0]           cnt;
  logic [D_WIDTH-1:0]   addr_q, wdata_q;
  logic                 write_q;
  logic [STRB_W-1:0]    strb_q;
  logic [2:0]           prot_q;

  logic                 setup, enter_access, acc_err, acc_write;
  logic [D_WIDTH-1:0]   acc_addr, acc_wdata, rd_data;
  logic [STRB_W-1:0]    acc_strb;

  assign setup = (state == IDLE) && psel && !penable;

  // A zero-wait transfer commits on the setup edge itself, before the
  // capture registers hold anything, so it must use the live bus values.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    acc_addr  = addr_q;
    acc_write = write_q;
    acc_wdata = wdata_q;
    acc_strb  = strb_q;
    if (state == IDLE) begin
      acc_addr  = paddr;
      acc_write = pwrite;
      acc_wdata = pwdata;
      acc_strb  = pstrb;
    end
  end

  assign enter_access = (setup && (wait_cfg == 4'd0)) ||
                        ((state == WAIT) && psel && (cnt == 4'd1));
  assign acc_err      = decode_err(acc_addr, acc_write, NUM_REGS) != ERR_NONE;

  apb_regfile_store #(
    .D_WIDTH  (D_WIDTH),
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_store (
    .pclk     (pclk),
    .presetn  (presetn),
    .we       (enter_access && acc_write && !acc_err),
    .idx      (acc_addr[2 +: IDX_W]),
    .wdata    (acc_wdata),
    .strb     (acc_strb),
    .rd_data  (rd_data),
    .reg_q    (reg_q),
    .wr_pulse (wr_pulse)
  );

  // NOTE: all state here uses <= so every register samples pre-edge values.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= IDLE;
      cnt     <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
    end else begin
      pready  <= enter_access;
      pslverr <= enter_access && acc_err;
      if (enter_access && !acc_write) prdata <= acc_err ? '0 : rd_data;

      case (state)
        IDLE: begin
          if (setup) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
            prot_q  <= pprot;
            cnt     <= wait_cfg;
            state   <= (wait_cfg == 4'd0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (!psel)              state <= IDLE;
          else if (cnt == 4'd1)   state <= ACCESS;
        end
        ACCESS:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_completer_regfile.md
Name: apb_completer_regfile

Overview:
APB4 completer (slave) terminating one psel line driven by the APB bridge. It decodes paddr into a bank of 32-bit registers, performs strobed writes and reads, inserts a runtime-programmable number of wait states, and signals pslverr on illegal accesses. Register contents and per-register write pulses are exported to downstream fabric logic.

Parameters:
D_WIDTH, 32, data/address width (matches `D_WIDTH)
NUM_REGS, 16, number of word registers (2..64)
ID_VALUE, 32'hA9B0_0001, reset/constant value of read-only register 0

Ports:
pclk  in  1  clock
presetn  in  1  asynchronous active-low reset
psel  in  1  select for this completer
penable  in  1  access-phase indicator
pwrite  in  1  1=write, 0=read
paddr  in  D_WIDTH  byte address, offset from completer base
pwdata  in  D_WIDTH  write data
pstrb  in  4  byte-lane write strobes
pprot  in  3  protection attributes (captured, reported in error only)
wait_cfg  in  4  wait states for next transfer (0..15), sampled in setup
prdata  out  D_WIDTH  read data
pready  out  1  transfer completion
pslverr  out  1  transfer error, valid only with pready
reg_q  out  NUM_REGS*D_WIDTH  flattened register contents, reg n at [n*32 +: 32]
wr_pulse  out  NUM_REGS  one-cycle pulse per committed register write

Behaviour:
- Reset (async assert, sync release on pclk): state=IDLE, pready=0, pslverr=0, prdata=0, wr_pulse=0, reg 0=ID_VALUE, regs 1..N-1=0.
- States: IDLE, WAIT, ACCESS.
- Setup detect: psel=1, penable=0 in IDLE. On that edge capture paddr, pwrite, pwdata, pstrb, pprot; load cnt=wait_cfg.
- IDLE -> ACCESS if wait_cfg=0; IDLE -> WAIT if wait_cfg>0.
- WAIT: cnt decrements each edge; cnt=1 -> ACCESS. pready=0 throughout.
- ACCESS: pready=1 for exactly one cycle; next edge -> IDLE unconditionally.
- Latency: pready is high in the (wait_cfg+1)-th cycle after the setup cycle. With wait_cfg=0, pready is high in the first penable cycle.
- Error decode, evaluated on captured values: paddr[1:0]!=0, word index >= NUM_REGS, or write to index 0. Any of these sets pslverr=1 in the ACCESS cycle; otherwise pslverr=0.
- Read: prdata is loaded on the edge entering ACCESS. Value is the register contents, or 0 on error. prdata holds its value afterwards.
- Write: on the edge entering ACCESS, if no error, update each byte lane i where pstrb[i]=1 and pulse wr_pulse[idx] for that one cycle. pstrb=0 gives a legal no-op write: pslverr=0, wr_pulse still pulses. Errored writes leave registers unchanged and produce no pulse.
- Abort: psel=0 during WAIT -> return to IDLE next edge, no commit, no pready.
- penable=1 seen in IDLE without a preceding setup cycle is ignored.
- Back-to-back: a setup in the cycle after ACCESS is accepted normally.
- Reset mid-transfer: immediate return to reset values. No partial write.

Decomposition:
- Package apb_pkg: state enum (IDLE/SETUP/ACCESS/WAIT), D_WIDTH, STRB_W=4, ID_VALUE default, error-cause constants.
- Sub-module apb_regfile_store: register array with byte-strobe write port, read mux, wr_pulse generation, and read-only reg 0. The completer FSM stays in the top module.

Test Plan:
- Reset, then read addr 0x0 with wait_cfg=0 -> pready in first access cycle, prdata=0xA9B00001, pslverr=0.
- Write 0x11223344 to 0x8 with pstrb=4'b0101, wait_cfg=0, over prior 0 -> reg2=0x00220044, wr_pulse[2] high one cycle, pslverr=0.
- Read 0x8 with wait_cfg=3 -> pready low for 3 access cycles, high on the 4th, prdata=0x00220044.
- Write to 0x0, 0x6, and 0x40 (NUM_REGS=16) -> pslverr=1 with pready each time; reg contents unchanged; no wr_pulse.
- Drop psel during WAIT (wait_cfg=5) -> FSM back to IDLE, no pready, no register change. A following read completes normally.
- Assert presetn=0 in WAIT of a write to 0x4 -> outputs clear immediately; reg1=0 after release.
